// File: rtl/pipelined_mac_unit.sv
// -----------------------------------------------------------------------------
// pipelined_mac_unit
//   Fully pipelined unsigned multiply / multiply-accumulate unit. One operand
//   pair per cycle, no backpressure, three register stages. A sample
//   registered at edge N appears on result/out_valid after edge N+2.
//
// Parameters
//   W      operand width of a and b (product is 2*W bits)
//   ACC_W  accumulator / result width, must be >= 2*W
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operand pair valid this cycle
//   a, b       in   unsigned operands (W bits)
//   mode       in   0 = multiply only, 1 = multiply-accumulate
//   acc_clr    in   accumulate into zero instead of the running sum (mode 1)
//   out_valid  out  result valid, one cycle per valid input sample
//   result     out  product (mode 0) or new accumulator value (mode 1)
//   ovf        out  sticky saturation flag
// -----------------------------------------------------------------------------
module pipelined_mac_unit #(
    parameter int W     = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             mode,
    input  logic             acc_clr,
    output logic             out_valid,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);

    localparam int P_W   = 2 * W;
    localparam int SUM_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    // The accumulator must be able to hold at least one full product.
    generate
        if (ACC_W < 2 * W) begin : g_bad_width
            $error("pipelined_mac_unit: ACC_W must be >= 2*W");
        end
    endgenerate

    // Stage 0 registers
    logic [W-1:0]     a_q, b_q;
    logic             v0_q, mode0_q, clr0_q;
    // Stage 1 registers
    logic [P_W-1:0]   p_q;
    logic             v1_q, mode1_q, clr1_q;
    // Stage 2 registers and their next-state values
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;
    // Stage 2 arithmetic
    logic [ACC_W-1:0] base_s;
    logic [SUM_W-1:0] sum_s;
    logic             sat_s;

    // Stage 0/1: capture operands and control, then form the product.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            v0_q    <= 1'b0;
            mode0_q <= 1'b0;
            clr0_q  <= 1'b0;
            p_q     <= {P_W{1'b0}};
            v1_q    <= 1'b0;
            mode1_q <= 1'b0;
            clr1_q  <= 1'b0;
        end else begin
            a_q     <= a;
            b_q     <= b;
            v0_q    <= in_valid;
            mode0_q <= mode;
            clr0_q  <= acc_clr;
            p_q     <= P_W'(a_q) * P_W'(b_q);
            v1_q    <= v0_q;
            mode1_q <= mode0_q;
            clr1_q  <= clr0_q;
        end
    end

    // Stage 2 next state: product pass-through or saturating accumulate.
    always_comb begin
        base_s      = {ACC_W{1'b0}};
        sum_s       = {SUM_W{1'b0}};
        sat_s       = 1'b0;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        if (v1_q) begin
            if (mode1_q) begin
                if (clr1_q) begin
                    base_s = {ACC_W{1'b0}};
                end else begin
                    base_s = acc_q;
                end
                // The sum never exceeds 2^(ACC_W+1)-1 because the product
                // fits in ACC_W bits, so the carry bit alone flags overflow.
                sum_s = SUM_W'(base_s) + SUM_W'(p_q);
                sat_s = sum_s[ACC_W];
                if (sat_s) begin
                    acc_d = ACC_MAX;
                end else begin
                    acc_d = sum_s[ACC_W-1:0];
                end
                // A clearing sample also restarts the sticky overflow history.
                if (clr1_q) begin
                    ovf_d = sat_s;
                end else begin
                    ovf_d = ovf_q | sat_s;
                end
                result_d = acc_d;
            end else begin
                result_d = ACC_W'(p_q);
            end
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= {ACC_W{1'b0}};
            result_q    <= {ACC_W{1'b0}};
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_mac_unit.sv
// -----------------------------------------------------------------------------
// tb_pipelined_mac_unit
//   Self-checking bench for pipelined_mac_unit (W=4, ACC_W=8). A behavioural
//   model computes each sample's outcome with integer arithmetic when the
//   sample is applied and queues it; outcomes emerge two edges later.
// -----------------------------------------------------------------------------
module tb_pipelined_mac_unit;

    localparam int MAXV = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       mode = 1'b0;
    logic       acc_clr = 1'b0;
    logic       out_valid;
    logic [7:0] result;
    logic       ovf;

    pipelined_mac_unit #(.W(4), .ACC_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .mode(mode), .acc_clr(acc_clr), .out_valid(out_valid),
        .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int r;
        bit o;
    } exp_t;

    exp_t q[$];
    int   m_acc, m_last;
    bit   m_ovf;
    int   checks = 0;
    int   errors = 0;
    logic       exp_v, exp_o;
    logic [7:0] exp_r;
    logic       obs_v [8];
    logic [7:0] obs_r [8];
    logic       obs_o [8];

    // Model: outcome of one sample, computed straight from the operation rules.
    task automatic model_push(input bit v, input int ai, input int bi, input bit m, input bit c);
        exp_t e;
        int p, s;
        bit sat;
        p = ai * bi;
        if (!v) begin
            e = '{v: 1'b0, r: m_last, o: m_ovf};
        end else if (!m) begin
            m_last = p;
            e = '{v: 1'b1, r: p, o: m_ovf};
        end else begin
            s     = (c ? 0 : m_acc) + p;
            sat   = (s > MAXV);
            m_acc = sat ? MAXV : s;
            m_ovf = c ? sat : (m_ovf | sat);
            m_last = m_acc;
            e = '{v: 1'b1, r: m_acc, o: m_ovf};
        end
        q.push_back(e);
    endtask

    // Apply one sample at the next edge, then load the expected outputs.
    task automatic cycle(input bit v, input int ai, input int bi, input bit m, input bit c);
        exp_t e;
        @(negedge clk);
        rst = 1'b0; in_valid = v; a = 4'(ai); b = 4'(bi); mode = m; acc_clr = c;
        @(posedge clk);
        #1;
        model_push(v, ai, bi, m, c);
        e = q.pop_front();
        exp_v = e.v; exp_r = e.r[7:0]; exp_o = e.o;
    endtask

    task automatic do_reset();
        exp_t idle;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; a = 4'd0; b = 4'd0; mode = 1'b0; acc_clr = 1'b0;
        @(posedge clk);
        #1;
        m_acc = 0; m_last = 0; m_ovf = 1'b0;
        idle = '{v: 1'b0, r: 0, o: 1'b0};
        q.delete();
        q.push_back(idle);
        q.push_back(idle);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || result !== 8'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: got v=%0b r=%0d o=%0b, want v=0 r=0 o=0", out_valid, result, ovf);
        end
    endtask

    // Runs a five-cycle stimulus table, checking every cycle against the model.
    task automatic test_multiply();
        int sv[5] = '{1, 0, 0, 0, 0};
        int sa[5] = '{3, 0, 0, 0, 0};
        int sb[5] = '{5, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            cycle(sv[i] != 0, sa[i], sb[i], 1'b0, 1'b0);
            checks++;
            if (out_valid !== exp_v || result !== exp_r || ovf !== exp_o) begin
                errors++;
                $display("FAIL multiply[%0d]: got v=%0b r=%0d o=%0b, want v=%0b r=%0d o=%0b", i, out_valid, result, ovf, exp_v, exp_r, exp_o);
            end
            obs_v[i] = out_valid; obs_r[i] = result; obs_o[i] = ovf;
        end
        checks++;
        if (obs_v[2] !== 1'b1 || obs_r[2] !== 8'd15 || obs_o[2] !== 1'b0 || obs_v[3] !== 1'b0 || obs_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL multiply_latency: got v1=%0b v2=%0b r2=%0d o2=%0b v3=%0b, want 0 1 15 0 0", obs_v[1], obs_v[2], obs_r[2], obs_o[2], obs_v[3]);
        end
    endtask

    task automatic test_back_to_back();
        int sa[5] = '{2, 4, 1, 0, 0};
        int sb[5] = '{3, 4, 7, 0, 0};
        int sv[5] = '{1, 1, 1, 0, 0};
        int sc[5] = '{1, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            cycle(sv[i] != 0, sa[i], sb[i], 1'b1, sc[i] != 0);
            checks++;
            if (out_valid !== exp_v || result !== exp_r || ovf !== exp_o) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got v=%0b r=%0d o=%0b, want v=%0b r=%0d o=%0b", i, out_valid, result, ovf, exp_v, exp_r, exp_o);
            end
            obs_v[i] = out_valid; obs_r[i] = result; obs_o[i] = ovf;
        end
        checks++;
        if (obs_r[2] !== 8'd6 || obs_r[3] !== 8'd22 || obs_r[4] !== 8'd29 || !(obs_v[2] && obs_v[3] && obs_v[4])) begin
            errors++;
            $display("FAIL back_to_back_seq: got %0d %0d %0d, want 6 22 29", obs_r[2], obs_r[3], obs_r[4]);
        end
    endtask

    task automatic test_saturation();
        int sa[5] = '{15, 15, 1, 0, 0};
        int sv[5] = '{1, 1, 1, 0, 0};
        int sc[5] = '{1, 0, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            cycle(sv[i] != 0, sa[i], sa[i], 1'b1, sc[i] != 0);
            checks++;
            if (out_valid !== exp_v || result !== exp_r || ovf !== exp_o) begin
                errors++;
                $display("FAIL saturation[%0d]: got v=%0b r=%0d o=%0b, want v=%0b r=%0d o=%0b", i, out_valid, result, ovf, exp_v, exp_r, exp_o);
            end
            obs_v[i] = out_valid; obs_r[i] = result; obs_o[i] = ovf;
        end
        checks++;
        if (obs_r[2] !== 8'd225 || obs_o[2] !== 1'b0 || obs_r[3] !== 8'd255 || obs_o[3] !== 1'b1 || obs_r[4] !== 8'd1 || obs_o[4] !== 1'b0) begin
            errors++;
            $display("FAIL saturation_seq: got %0d/%0b %0d/%0b %0d/%0b, want 225/0 255/1 1/0", obs_r[2], obs_o[2], obs_r[3], obs_o[3], obs_r[4], obs_o[4]);
        end
    endtask

    task automatic test_bubble();
        int sv[5] = '{1, 0, 1, 0, 0};
        int sc[5] = '{1, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            cycle(sv[i] != 0, 2, 2, 1'b1, sc[i] != 0);
            checks++;
            if (out_valid !== exp_v || result !== exp_r || ovf !== exp_o) begin
                errors++;
                $display("FAIL bubble[%0d]: got v=%0b r=%0d o=%0b, want v=%0b r=%0d o=%0b", i, out_valid, result, ovf, exp_v, exp_r, exp_o);
            end
            obs_v[i] = out_valid; obs_r[i] = result; obs_o[i] = ovf;
        end
        checks++;
        if (obs_v[2] !== 1'b1 || obs_v[3] !== 1'b0 || obs_v[4] !== 1'b1 || obs_r[2] !== 8'd4 || obs_r[3] !== 8'd4 || obs_r[4] !== 8'd8) begin
            errors++;
            $display("FAIL bubble_seq: got v=%0b%0b%0b r=%0d %0d %0d, want v=101 r=4 4 8", obs_v[2], obs_v[3], obs_v[4], obs_r[2], obs_r[3], obs_r[4]);
        end
    endtask

    task automatic test_mixed_modes();
        int sa[5] = '{4, 3, 1, 0, 0};
        int sb[5] = '{5, 3, 1, 0, 0};
        int sv[5] = '{1, 1, 1, 0, 0};
        int sm[5] = '{1, 0, 1, 1, 1};
        int sc[5] = '{1, 1, 0, 1, 1};
        for (int i = 0; i < 5; i++) begin
            cycle(sv[i] != 0, sa[i], sb[i], sm[i] != 0, sc[i] != 0);
            checks++;
            if (out_valid !== exp_v || result !== exp_r || ovf !== exp_o) begin
                errors++;
                $display("FAIL mixed[%0d]: got v=%0b r=%0d o=%0b, want v=%0b r=%0d o=%0b", i, out_valid, result, ovf, exp_v, exp_r, exp_o);
            end
            obs_v[i] = out_valid; obs_r[i] = result; obs_o[i] = ovf;
        end
        checks++;
        if (obs_r[2] !== 8'd20 || obs_r[3] !== 8'd9 || obs_r[4] !== 8'd21) begin
            errors++;
            $display("FAIL mixed_seq: got %0d %0d %0d, want 20 9 21", obs_r[2], obs_r[3], obs_r[4]);
        end
    endtask

    task automatic test_reset_in_flight();
        cycle(1'b1, 15, 15, 1'b1, 1'b1);
        cycle(1'b1, 15, 15, 1'b1, 1'b0);
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || result !== 8'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL flight_reset: got v=%0b r=%0d o=%0b, want 0 0 0", out_valid, result, ovf);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(i == 1, 2, 2, 1'b1, 1'b0);
            checks++;
            if (out_valid !== exp_v || result !== exp_r || ovf !== exp_o) begin
                errors++;
                $display("FAIL flight[%0d]: got v=%0b r=%0d o=%0b, want v=%0b r=%0d o=%0b", i, out_valid, result, ovf, exp_v, exp_r, exp_o);
            end
            obs_v[i] = out_valid; obs_r[i] = result; obs_o[i] = ovf;
        end
        checks++;
        if (obs_v[0] !== 1'b0 || obs_v[3] !== 1'b1 || obs_r[3] !== 8'd4 || obs_o[3] !== 1'b0) begin
            errors++;
            $display("FAIL flight_after: got v0=%0b v3=%0b r3=%0d o3=%0b, want 0 1 4 0", obs_v[0], obs_v[3], obs_r[3], obs_o[3]);
        end
    endtask

    task automatic test_random();
        int ai, bi;
        bit v, m, c;
        for (int i = 0; i < 400; i++) begin
            ai = $urandom_range(0, 15);
            bi = $urandom_range(0, 15);
            v  = ($urandom_range(0, 3) != 0);
            m  = ($urandom_range(0, 2) != 0);
            c  = ($urandom_range(0, 6) == 0);
            cycle(v, ai, bi, m, c);
            checks++;
            if (out_valid !== exp_v || result !== exp_r || ovf !== exp_o) begin
                errors++;
                $display("FAIL random[%0d]: got v=%0b r=%0d o=%0b, want v=%0b r=%0d o=%0b", i, out_valid, result, ovf, exp_v, exp_r, exp_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_back_to_back();
        test_saturation();
        test_bubble();
        test_mixed_modes();
        test_reset_in_flight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
